// File: rtl/sfr_target.sv
// sfr_target -- register bank answering the single-cycle SFR bus.
//
// Purpose: holds CTRL, STATUS, IRQ_PEND/IRQ_MASK, WR_CNT and ERR registers,
// plus an optional scratch array, and raises a registered interrupt.
//
// Optional feature macro: SFR_TARGET_SCRATCH_EN
//   defined     -> NUM_SCRATCH read/write scratch registers at 0x10..
//   not defined -> those addresses are unmapped
//
// Ports:
//   clk         bus clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   address     register address, valid with we or re
//   write_data  write data, valid with we
//   we, re      single-cycle write / read strobes
//   read_data   combinational read data while re = 1, else 0
//   hw_status   live hardware status bits (synchronous to clk)
//   ctrl_out    mirror of CTRL
//   irq         registered interrupt request
module sfr_target #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SCRATCH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [DATA_WIDTH-1:0] hw_status,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_PEND   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_MASK   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_WRCNT  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_ERR    = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_SCR    = ADDR_WIDTH'(16);

`ifdef SFR_TARGET_SCRATCH_EN
    localparam bit SCRATCH_EN = 1'b1;
`else
    localparam bit SCRATCH_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] pend_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] cnt_q;
    logic [1:0]            err_q;
    logic                  irq_q;

    logic [ADDR_WIDTH-1:0] scratch_off;
    logic                  in_scratch;
    logic                  mapped;
    logic                  collision;
    logic                  unmapped;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] pend_clr;
    logic [1:0]            err_clr;

    // Address decode. The scratch window is only mapped when the array exists.
    assign scratch_off = address - A_SCR;
    assign in_scratch  = SCRATCH_EN && (address >= A_SCR)
                         && (scratch_off < ADDR_WIDTH'(NUM_SCRATCH));
    assign mapped      = (address <= A_ERR) || in_scratch;

    // A write is accepted only when it is not colliding with a read, hits a
    // mapped register and is not aimed at the read-only STATUS register.
    assign collision = we && re;
    assign unmapped  = (we || re) && !mapped;
    assign wr_ok     = we && !re && mapped && (address != A_STATUS);

    assign pend_clr = (wr_ok && address == A_PEND) ? write_data : '0;
    assign err_clr  = (wr_ok && address == A_ERR) ? write_data[1:0] : 2'b00;

`ifdef SFR_TARGET_SCRATCH_EN
    localparam int IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];
    logic [IDX_W-1:0]      scratch_sel;

    assign scratch_sel = scratch_off[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (wr_ok && in_scratch) begin
            scratch_q[scratch_sel] <= write_data;
        end
    end
`endif

    // Core register bank. Hardware sets (pending edges, error flags) are ORed
    // in after the W1C clear so that a same-cycle set always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            status_q <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= hw_status;
            pend_q   <= (pend_q & ~pend_clr) | (hw_status & ~status_q);
            err_q    <= (err_q & ~err_clr) | {unmapped, collision};
            // Uses the pre-edge pending/mask values, so irq lags IRQ_PEND by one edge.
            irq_q    <= |(pend_q & mask_q);

            if (wr_ok && address == A_CTRL) begin
                ctrl_q <= write_data;
            end
            if (wr_ok && address == A_MASK) begin
                mask_q <= write_data;
            end
            if (wr_ok) begin
                if (address == A_WRCNT) begin
                    cnt_q <= '0;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + DATA_WIDTH'(1);
                end
            end
        end
    end

    // Zero-wait-state read mux; unmapped addresses and idle cycles return 0.
    always_comb begin
        read_data = '0;
        if (re) begin
            case (address)
                A_CTRL:   read_data = ctrl_q;
                A_STATUS: read_data = status_q;
                A_PEND:   read_data = pend_q;
                A_MASK:   read_data = mask_q;
                A_WRCNT:  read_data = cnt_q;
                A_ERR:    read_data = DATA_WIDTH'(err_q);
                default:  read_data = '0;
            endcase
`ifdef SFR_TARGET_SCRATCH_EN
            if (in_scratch) begin
                read_data = scratch_q[scratch_sel];
            end
`endif
        end
    end

    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_sfr_target.sv
// tb_sfr_target -- self-checking bench for sfr_target (default 8/8/8 sizing).
// Directed scenarios plus a randomized run compared against a transaction-level
// reference model of the register map.
module tb_sfr_target;

`ifdef SFR_TARGET_SCRATCH_EN
    localparam bit SCR_EN = 1'b1;
`else
    localparam bit SCR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] write_data;
    logic       we;
    logic       re;
    logic [7:0] read_data;
    logic [7:0] hw_status;
    logic [7:0] ctrl_out;
    logic       irq;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    logic [7:0] m_ctrl, m_sq, m_pend, m_mask, m_cnt;
    logic [1:0] m_err;
    logic       m_irq;
    logic [7:0] m_scr [8];
    logic [7:0] hw_now;

    sfr_target #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SCRATCH(8)) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .write_data(write_data),
        .we(we),
        .re(re),
        .read_data(read_data),
        .hw_status(hw_status),
        .ctrl_out(ctrl_out),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_mapped(input logic [7:0] a);
        return (a <= 8'h05) || (SCR_EN && a >= 8'h10 && a <= 8'h17);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (SCR_EN && a >= 8'h10 && a <= 8'h17) return m_scr[a - 8'h10];
        case (a)
            8'h00:   return m_ctrl;
            8'h01:   return m_sq;
            8'h02:   return m_pend;
            8'h03:   return m_mask;
            8'h04:   return m_cnt;
            8'h05:   return {6'b0, m_err};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_sq = 0; m_pend = 0; m_mask = 0; m_cnt = 0; m_err = 0; m_irq = 0;
        for (int i = 0; i < 8; i++) m_scr[i] = 0;
    endtask

    // One bus cycle: drive at the falling edge, sample read_data mid-cycle,
    // advance the model at the rising edge. rd/exp return the observed and
    // model read values for the caller to compare.
    task automatic bus_cycle(input logic w, input logic r, input logic [7:0] a,
                             input logic [7:0] d, output logic [7:0] rd,
                             output logic [7:0] exp);
        logic       acc;
        logic       nirq;
        logic [7:0] rise;
        logic [1:0] eset;
        @(negedge clk);
        we = w; re = r; address = a; write_data = d; hw_status = hw_now;
        exp = r ? m_read(a) : 8'h00;
        #1 rd = read_data;
        @(posedge clk);
        nirq = |(m_pend & m_mask);
        rise = hw_now & ~m_sq;
        eset = {(w || r) && !m_mapped(a), w && r};
        acc  = w && !r && m_mapped(a) && a != 8'h01;
        if (acc) begin
            if (a == 8'h00) m_ctrl = d;
            if (a == 8'h02) m_pend = m_pend & ~d;
            if (a == 8'h03) m_mask = d;
            if (a == 8'h05) m_err = m_err & ~d[1:0];
            if (a >= 8'h10) m_scr[a - 8'h10] = d;
            if (a == 8'h04) m_cnt = 0;
            else if (m_cnt < 8'd255) m_cnt = m_cnt + 1;
        end
        m_pend = m_pend | rise;
        m_err  = m_err | eset;
        m_sq   = hw_now;
        m_irq  = nirq;
        #1 we = 0; re = 0;
    endtask

    task automatic test_reset();
        logic [7:0] rd, ex;
        reset = 0; we = 0; re = 0; address = 0; write_data = 0; hw_now = 0; hw_status = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctrl_out !== 8'h00 || irq !== 1'b0 || read_data !== 8'h00)
            $display("[TB] FAIL reset_outputs: ctrl_out=%h irq=%b read_data=%h expected 00/0/00", ctrl_out, irq, read_data);
        else passes++;
        @(negedge clk) reset = 1;
        for (int a = 0; a <= 5; a++) begin
            bus_cycle(0, 1, 8'(a), 8'h00, rd, ex);
            checks++;
            if (rd !== 8'h00) $display("[TB] FAIL reset_read_%0d: got %h expected 00", a, rd);
            else passes++;
        end
    endtask

    task automatic test_ctrl_wrcnt();
        logic [7:0] rd, ex;
        bus_cycle(1, 0, 8'h00, 8'hA5, rd, ex);
        bus_cycle(0, 1, 8'h00, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'hA5 || ctrl_out !== 8'hA5)
            $display("[TB] FAIL ctrl_rw: read=%h ctrl_out=%h expected a5", rd, ctrl_out);
        else passes++;
        bus_cycle(0, 1, 8'h04, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01) $display("[TB] FAIL wrcnt_one: got %h expected 01", rd);
        else passes++;
        for (int i = 0; i < 255; i++) bus_cycle(1, 0, 8'h00, 8'($urandom), rd, ex);
        bus_cycle(0, 1, 8'h04, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'hFF) $display("[TB] FAIL wrcnt_sat: got %h expected ff", rd);
        else passes++;
        bus_cycle(1, 0, 8'h04, 8'h37, rd, ex);
        bus_cycle(0, 1, 8'h04, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h00) $display("[TB] FAIL wrcnt_clear: got %h expected 00", rd);
        else passes++;
    endtask

    task automatic test_irq();
        logic [7:0] rd, ex;
        hw_now = 8'h00;
        bus_cycle(1, 0, 8'h03, 8'h02, rd, ex);
        hw_now = 8'h03;
        bus_cycle(0, 0, 8'h00, 8'h00, rd, ex);
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL irq_not_yet: got %b expected 0", irq);
        else passes++;
        bus_cycle(0, 1, 8'h02, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h03 || irq !== 1'b1)
            $display("[TB] FAIL irq_pend_set: pend=%h irq=%b expected 03/1", rd, irq);
        else passes++;
        bus_cycle(1, 0, 8'h02, 8'h02, rd, ex);
        bus_cycle(0, 1, 8'h02, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01 || irq !== 1'b0)
            $display("[TB] FAIL irq_w1c: pend=%h irq=%b expected 01/0", rd, irq);
        else passes++;
        hw_now = 8'h00;
        bus_cycle(0, 0, 8'h00, 8'h00, rd, ex);
        hw_now = 8'h01;
        bus_cycle(1, 0, 8'h02, 8'h01, rd, ex);
        bus_cycle(0, 1, 8'h02, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01) $display("[TB] FAIL pend_set_wins: got %h expected 01", rd);
        else passes++;
        bus_cycle(0, 1, 8'h01, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01) $display("[TB] FAIL status_read: got %h expected 01", rd);
        else passes++;
    endtask

    task automatic test_collision();
        logic [7:0] rd, ex, cnt_before;
        bus_cycle(1, 0, 8'h00, 8'h11, rd, ex);
        bus_cycle(0, 1, 8'h04, 8'h00, cnt_before, ex);
        bus_cycle(1, 1, 8'h00, 8'h5A, rd, ex);
        checks++;
        if (rd !== 8'h11 || ctrl_out !== 8'h11)
            $display("[TB] FAIL collision_ctrl: read=%h ctrl_out=%h expected 11", rd, ctrl_out);
        else passes++;
        bus_cycle(0, 1, 8'h05, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01) $display("[TB] FAIL collision_err: got %h expected 01", rd);
        else passes++;
        bus_cycle(0, 1, 8'h04, 8'h00, rd, ex);
        checks++;
        if (rd !== cnt_before) $display("[TB] FAIL collision_wrcnt: got %h expected %h", rd, cnt_before);
        else passes++;
        bus_cycle(1, 0, 8'h05, 8'h01, rd, ex);
        bus_cycle(0, 1, 8'h05, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h00) $display("[TB] FAIL err_w1c: got %h expected 00", rd);
        else passes++;
    endtask

    task automatic test_unmapped();
        logic [7:0] rd, ex;
        bus_cycle(0, 1, 8'h08, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h00) $display("[TB] FAIL unmapped_read: got %h expected 00", rd);
        else passes++;
        bus_cycle(0, 1, 8'h05, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h02) $display("[TB] FAIL unmapped_err: got %h expected 02", rd);
        else passes++;
        bus_cycle(1, 0, 8'h05, 8'h02, rd, ex);
        bus_cycle(1, 0, 8'h17, 8'h3C, rd, ex);
        bus_cycle(0, 1, 8'h17, 8'h00, rd, ex);
        checks++;
        if (rd !== (SCR_EN ? 8'h3C : 8'h00))
            $display("[TB] FAIL scratch_read: got %h expected %h", rd, SCR_EN ? 8'h3C : 8'h00);
        else passes++;
        bus_cycle(0, 1, 8'h05, 8'h00, rd, ex);
        checks++;
        if (rd !== (SCR_EN ? 8'h00 : 8'h02))
            $display("[TB] FAIL scratch_err: got %h expected %h", rd, SCR_EN ? 8'h00 : 8'h02);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] rd, ex, a;
        logic       w, r;
        int         k, bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 4)      a = 8'($urandom_range(0, 5));
            else if (k == 5) a = 8'($urandom_range(6, 15));
            else if (k <= 7) a = 8'($urandom_range(16, 23));
            else if (k == 8) a = 8'($urandom_range(24, 31));
            else             a = 8'($urandom);
            k = $urandom_range(0, 9);
            w = (k <= 3) || (k == 8);
            r = (k >= 4 && k <= 8);
            if ($urandom_range(0, 3) == 0) hw_now = 8'($urandom);
            bus_cycle(w, r, a, 8'($urandom), rd, ex);
            checks++;
            if (rd !== ex || ctrl_out !== m_ctrl || irq !== m_irq) begin
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random_%0d: addr=%h read=%h/%h ctrl_out=%h/%h irq=%b/%b (got/expected)",
                             n, a, rd, ex, ctrl_out, m_ctrl, irq, m_irq);
            end else passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] rd, ex;
        hw_now = 8'h00;
        bus_cycle(1, 0, 8'h00, 8'hFF, rd, ex);
        bus_cycle(1, 0, 8'h03, 8'hFF, rd, ex);
        hw_now = 8'h01;
        bus_cycle(0, 0, 8'h00, 8'h00, rd, ex);
        bus_cycle(0, 0, 8'h00, 8'h00, rd, ex);
        checks++;
        if (irq !== 1'b1 || ctrl_out !== 8'hFF)
            $display("[TB] FAIL pre_reset_state: irq=%b ctrl_out=%h expected 1/ff", irq, ctrl_out);
        else passes++;
        @(posedge clk);
        #2 reset = 0;
        #1;
        checks++;
        if (irq !== 1'b0 || ctrl_out !== 8'h00)
            $display("[TB] FAIL async_reset: irq=%b ctrl_out=%h expected 0/00", irq, ctrl_out);
        else passes++;
        model_reset();
        @(negedge clk);
        we = 1; address = 8'h00; write_data = 8'h77;
        @(negedge clk);
        we = 0; reset = 1;
        bus_cycle(0, 1, 8'h00, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h00) $display("[TB] FAIL no_write_in_reset: got %h expected 00", rd);
        else passes++;
        bus_cycle(0, 1, 8'h02, 8'h00, rd, ex);
        checks++;
        if (rd !== 8'h01) $display("[TB] FAIL pend_after_reset: got %h expected 01", rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_ctrl_wrcnt();
        test_irq();
        test_collision();
        test_unmapped();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
